// File: rtl/decoder_scan_nx_pkg.sv
// Shared mode encodings and the dwell-counter sizing helper for the scan decoder family.
package decoder_scan_nx_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    // Width needed to count 0..dwell-1; never narrower than one bit so DWELL=1 still has a register.
    function automatic int cnt_width(input int dwell);
        int w;
        w = 1;
        while ((1 << w) < dwell) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/decoder_nx2n.sv
// Purpose: generalised N-to-2^N one-hot decoder, active-low enable and active-low outputs.
// Latency: combinational, zero cycles.
// Backpressure: none; e_n high blanks every output.
module decoder_nx2n #(
    parameter int N = 4
) (
    input  logic           e_n,
    input  logic [N-1:0]   a,
    output logic [2**N-1:0] d
);

    always_comb begin
        d = '1;
        for (int i = 0; i < 2**N; i++) begin
            if (!e_n && (a == N'(i))) begin
                d[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/decoder_scan_nx.sv
// Purpose: registered one-hot active-low select, either a latched address or a dwell-timed scan.
// Latency: one clock from any input to D/idx/wrap.
// Backpressure: none; E high blanks D and freezes the scan position and dwell count.
module decoder_scan_nx
    import decoder_scan_nx_pkg::*;
#(
    parameter int N         = 4,
    parameter int DWELL     = 4,
    parameter int SCAN_LAST = 2**N - 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            E,
    input  logic            mode,
    input  logic            load,
    input  logic [N-1:0]    A,
    output logic [2**N-1:0] D,
    output logic [N-1:0]    idx,
    output logic            wrap
);

    localparam int CW = cnt_width(DWELL);

    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic [N-1:0]    idx_nxt;
    logic            wrap_nxt;
    logic [2**N-1:0] d_nxt;

    always_comb begin
        idx_nxt  = idx;
        cnt_nxt  = cnt;
        wrap_nxt = 1'b0;
        if (mode_e'(mode) == MODE_DIRECT) begin
            // Direct mode keeps cnt at zero so a later switch to scan holds idx for a full dwell.
            cnt_nxt = '0;
            if (load) begin
                idx_nxt = A;
            end
        end else if (!E) begin
            if (cnt == CW'(DWELL - 1)) begin
                cnt_nxt = '0;
                // Anything at or past the last scan slot, including leftovers from direct mode, wraps.
                if (idx < N'(SCAN_LAST)) begin
                    idx_nxt = idx + N'(1);
                end else begin
                    idx_nxt  = '0;
                    wrap_nxt = 1'b1;
                end
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    decoder_nx2n #(
        .N (N)
    ) u_dec (
        .e_n (E),
        .a   (idx_nxt),
        .d   (d_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            D    <= '1;
            idx  <= '0;
            cnt  <= '0;
            wrap <= 1'b0;
        end else begin
            D    <= d_nxt;
            idx  <= idx_nxt;
            cnt  <= cnt_nxt;
            wrap <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_decoder_scan_nx.sv
// Directed bench for decoder_scan_nx: direct, enable, async reset, scan, out-of-range entry and corner dwell settings.
module tb_decoder_scan_nx;

    logic        clk;
    logic        rst;
    logic        E;
    logic        mode;
    logic        load;
    logic [3:0]  A;

    logic [15:0] d0, d1, d2;
    logic [3:0]  idx0, idx1, idx2;
    logic        wrap0, wrap1, wrap2;

    int n_tests;
    int n_fail;

    decoder_scan_nx #(.N(4), .DWELL(4), .SCAN_LAST(5)) dut (
        .clk(clk), .rst(rst), .E(E), .mode(mode), .load(load), .A(A),
        .D(d0), .idx(idx0), .wrap(wrap0)
    );

    decoder_scan_nx #(.N(4), .DWELL(1), .SCAN_LAST(3)) dut_fast (
        .clk(clk), .rst(rst), .E(E), .mode(mode), .load(load), .A(A),
        .D(d1), .idx(idx1), .wrap(wrap1)
    );

    decoder_scan_nx #(.N(4), .DWELL(2), .SCAN_LAST(0)) dut_one (
        .clk(clk), .rst(rst), .E(E), .mode(mode), .load(load), .A(A),
        .D(d2), .idx(idx2), .wrap(wrap2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [15:0] sel(input int i);
        logic [15:0] v;
        v = '1;
        v[i] = 1'b0;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; E = 1'b1; mode = 1'b0; load = 1'b0; A = 4'd0;
        tick(); tick();
        n_tests++; if (d0 !== 16'hFFFF) begin n_fail++; $display("FAIL reset_d: got %h want FFFF", d0); end
        n_tests++; if (idx0 !== 4'd0) begin n_fail++; $display("FAIL reset_idx: got %0d want 0", idx0); end
        n_tests++; if (wrap0 !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b want 0", wrap0); end
        rst = 1'b0;
        tick();
        n_tests++; if (d0 !== 16'hFFFF) begin n_fail++; $display("FAIL reset_disabled_d: got %h want FFFF", d0); end
    endtask

    task automatic test_direct();
        E = 1'b0; mode = 1'b0; A = 4'd9; load = 1'b1;
        tick();
        load = 1'b0;
        n_tests++; if (idx0 !== 4'd9) begin n_fail++; $display("FAIL direct_idx: got %0d want 9", idx0); end
        n_tests++; if (d0 !== 16'hFDFF) begin n_fail++; $display("FAIL direct_d: got %h want FDFF", d0); end
        A = 4'd3;
        tick(); tick();
        n_tests++; if (idx0 !== 4'd9) begin n_fail++; $display("FAIL direct_hold_idx: got %0d want 9", idx0); end
        n_tests++; if (d0 !== 16'hFDFF) begin n_fail++; $display("FAIL direct_hold_d: got %h want FDFF", d0); end
    endtask

    task automatic test_enable();
        E = 1'b1;
        tick();
        n_tests++; if (d0 !== 16'hFFFF) begin n_fail++; $display("FAIL enable_blank_d: got %h want FFFF", d0); end
        n_tests++; if (idx0 !== 4'd9) begin n_fail++; $display("FAIL enable_blank_idx: got %0d want 9", idx0); end
        E = 1'b0;
        tick();
        n_tests++; if (d0 !== 16'hFDFF) begin n_fail++; $display("FAIL enable_restore_d: got %h want FDFF", d0); end
        E = 1'b1; A = 4'd2; load = 1'b1;
        tick();
        load = 1'b0;
        n_tests++; if (idx0 !== 4'd2) begin n_fail++; $display("FAIL load_disabled_idx: got %0d want 2", idx0); end
        n_tests++; if (d0 !== 16'hFFFF) begin n_fail++; $display("FAIL load_disabled_d: got %h want FFFF", d0); end
        E = 1'b0;
        tick();
        n_tests++; if (d0 !== 16'hFFFB) begin n_fail++; $display("FAIL load_disabled_restore_d: got %h want FFFB", d0); end
    endtask

    task automatic test_async_reset();
        #3;
        rst = 1'b1;
        #1;
        n_tests++; if (d0 !== 16'hFFFF) begin n_fail++; $display("FAIL async_reset_d: got %h want FFFF", d0); end
        n_tests++; if (idx0 !== 4'd0) begin n_fail++; $display("FAIL async_reset_idx: got %0d want 0", idx0); end
        n_tests++; if (wrap0 !== 1'b0) begin n_fail++; $display("FAIL async_reset_wrap: got %b want 0", wrap0); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_scan();
        int exp_idx;
        int wraps;
        wraps = 0;
        E = 1'b0; mode = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            exp_idx = (c / 4) % 6;
            if (wrap0 === 1'b1 && c <= 24) wraps++;
            n_tests++; if (idx0 !== 4'(exp_idx)) begin n_fail++; $display("FAIL scan_idx c=%0d: got %0d want %0d", c, idx0, exp_idx); end
            n_tests++; if (d0 !== sel(exp_idx)) begin n_fail++; $display("FAIL scan_d c=%0d: got %h want %h", c, d0, sel(exp_idx)); end
            n_tests++; if (wrap0 !== ((c % 24) == 0)) begin n_fail++; $display("FAIL scan_wrap c=%0d: got %b want %b", c, wrap0, (c % 24) == 0); end
        end
        n_tests++; if (wraps != 1) begin n_fail++; $display("FAIL scan_wrap_count: got %0d want 1", wraps); end
    endtask

    task automatic test_out_of_range();
        mode = 1'b0; A = 4'd12; load = 1'b1;
        tick();
        load = 1'b0;
        n_tests++; if (idx0 !== 4'd12) begin n_fail++; $display("FAIL oor_load_idx: got %0d want 12", idx0); end
        mode = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_tests++; if (idx0 !== 4'd12 || wrap0 !== 1'b0) begin n_fail++; $display("FAIL oor_hold c=%0d: got idx %0d wrap %b want idx 12 wrap 0", c, idx0, wrap0); end
        end
        tick();
        n_tests++; if (idx0 !== 4'd0 || wrap0 !== 1'b1) begin n_fail++; $display("FAIL oor_wrap: got idx %0d wrap %b want idx 0 wrap 1", idx0, wrap0); end
        n_tests++; if (d0 !== 16'hFFFE) begin n_fail++; $display("FAIL oor_wrap_d: got %h want FFFE", d0); end
    endtask

    task automatic test_load_in_scan();
        A = 4'd7; load = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_tests++; if (idx0 !== 4'd0 || wrap0 !== 1'b0) begin n_fail++; $display("FAIL scan_load_ignored c=%0d: got idx %0d wrap %b want idx 0 wrap 0", c, idx0, wrap0); end
        end
        tick();
        load = 1'b0;
        n_tests++; if (idx0 !== 4'd1) begin n_fail++; $display("FAIL scan_load_advance: got %0d want 1", idx0); end
    endtask

    task automatic test_freeze();
        tick(); tick();
        E = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            n_tests++; if (d0 !== 16'hFFFF || idx0 !== 4'd1 || wrap0 !== 1'b0) begin n_fail++; $display("FAIL freeze c=%0d: got d %h idx %0d want d FFFF idx 1", c, d0, idx0); end
        end
        E = 1'b0;
        tick();
        n_tests++; if (idx0 !== 4'd1 || d0 !== 16'hFFFD) begin n_fail++; $display("FAIL resume_hold: got idx %0d d %h want idx 1 d FFFD", idx0, d0); end
        tick();
        n_tests++; if (idx0 !== 4'd2 || d0 !== 16'hFFFB) begin n_fail++; $display("FAIL resume_advance: got idx %0d d %h want idx 2 d FFFB", idx0, d0); end
    endtask

    task automatic test_mode_switch();
        tick();
        mode = 1'b0;
        tick();
        n_tests++; if (idx0 !== 4'd2) begin n_fail++; $display("FAIL direct_freeze_idx: got %0d want 2", idx0); end
        mode = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_tests++; if (idx0 !== 4'd2) begin n_fail++; $display("FAIL rescan_hold c=%0d: got %0d want 2", c, idx0); end
        end
        tick();
        n_tests++; if (idx0 !== 4'd3) begin n_fail++; $display("FAIL rescan_advance: got %0d want 3", idx0); end
    endtask

    task automatic test_dwell_corners();
        rst = 1'b1;
        tick();
        E = 1'b0; mode = 1'b1; load = 1'b0;
        rst = 1'b0;
        n_tests++; if (idx1 !== 4'd0 || d1 !== 16'hFFFF) begin n_fail++; $display("FAIL fast_reset: got idx %0d d %h want idx 0 d FFFF", idx1, d1); end
        for (int c = 1; c <= 8; c++) begin
            tick();
            n_tests++; if (idx1 !== 4'(c % 4)) begin n_fail++; $display("FAIL fast_idx c=%0d: got %0d want %0d", c, idx1, c % 4); end
            n_tests++; if (d1 !== sel(c % 4)) begin n_fail++; $display("FAIL fast_d c=%0d: got %h want %h", c, d1, sel(c % 4)); end
            n_tests++; if (wrap1 !== ((c % 4) == 0)) begin n_fail++; $display("FAIL fast_wrap c=%0d: got %b want %b", c, wrap1, (c % 4) == 0); end
            n_tests++; if (idx2 !== 4'd0 || d2 !== 16'hFFFE) begin n_fail++; $display("FAIL single_idx c=%0d: got idx %0d d %h want idx 0 d FFFE", c, idx2, d2); end
            n_tests++; if (wrap2 !== ((c % 2) == 0)) begin n_fail++; $display("FAIL single_wrap c=%0d: got %b want %b", c, wrap2, (c % 2) == 0); end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_direct();
        test_enable();
        test_async_reset();
        test_scan();
        test_out_of_range();
        test_load_in_scan();
        test_freeze();
        test_mode_switch();
        test_dwell_corners();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
